// File: rtl/slice_tx_arbiter.sv
// Slice-aware round-robin transmit arbiter: grants a queue only if its frame plus
// a guard fits in the time remaining in that queue's TDMA slice.
module slice_tx_arbiter #(
  parameter int unsigned DUR_WIDTH      = 25,
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter int unsigned TIMEOUT_MARGIN = 1000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [3:0]             slice_en,
  input  logic [4*DUR_WIDTH-1:0] slice_len,
  input  logic [3:0]             tx_req,
  input  logic [4*DUR_WIDTH-1:0] tx_dur,
  input  logic                   tx_done,
  output logic [3:0]             tx_grant,
  output logic                   tx_busy,
  output logic                   tx_abort,
  output logic                   slice_overrun,
  input  logic                   overrun_clr
);

  localparam int unsigned TW = DUR_WIDTH + 2;
  localparam logic [DUR_WIDTH:0] GUARD   = (DUR_WIDTH+1)'(GUARD_CYCLES);
  localparam logic [TW-1:0]      TMARGIN = TW'(TIMEOUT_MARGIN);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q, state_d;
  logic [DUR_WIDTH-1:0] remain_q [4];
  logic [DUR_WIDTH-1:0] remain_d [4];
  logic [DUR_WIDTH-1:0] dur_a    [4];
  logic [3:0]           slice_en_q;
  logic [1:0]           rr_q, rr_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           grant_q, grant_d;
  logic                 abort_q, abort_d;
  logic                 ovr_q, ovr_d;
  logic [3:0]           elig;
  logic                 pick_vld;
  logic [1:0]           pick;

  // Eligibility uses the previous-cycle enable, so the rising-edge cycle never qualifies.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      dur_a[i]    = tx_dur[i*DUR_WIDTH +: DUR_WIDTH];
      remain_d[i] = '0;
      if (slice_en[i] && !slice_en_q[i]) begin
        remain_d[i] = slice_len[i*DUR_WIDTH +: DUR_WIDTH];
      end else if (slice_en[i] && (remain_q[i] != '0)) begin
        remain_d[i] = remain_q[i] - DUR_WIDTH'(1);
      end
      elig[i] = slice_en[i] & slice_en_q[i] & tx_req[i] &
                ({1'b0, remain_q[i]} >= ({1'b0, dur_a[i]} + GUARD));
    end
  end

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int unsigned o = 0; o < 4; o++) begin
      if (!pick_vld && elig[2'(rr_q + 2'(o))]) begin
        pick_vld = 1'b1;
        pick     = 2'(rr_q + 2'(o));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    timer_d = timer_q;
    rr_d    = rr_q;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          grant_d = 4'b0001 << pick;
          timer_d = {2'b00, dur_a[pick]} + TMARGIN;
          rr_d    = pick + 2'd1;
        end
      end
      BUSY: begin
        // tx_done outranks an expiring timer in the same cycle.
        if (tx_done) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (timer_q == '0) begin
          state_d = IDLE;
          grant_d = '0;
          abort_d = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovr_d = ovr_q;
    if (overrun_clr) ovr_d = 1'b0;
    if ((state_q == BUSY) && ((slice_en & grant_q) == '0)) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      remain_q   <= '{default: '0};
      slice_en_q <= '0;
      rr_q       <= '0;
      timer_q    <= '0;
      grant_q    <= '0;
      abort_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      slice_en_q <= slice_en;
      rr_q       <= rr_d;
      timer_q    <= timer_d;
      grant_q    <= grant_d;
      abort_q    <= abort_d;
      ovr_q      <= ovr_d;
    end
  end

  assign tx_grant      = grant_q;
  assign tx_busy       = (state_q == BUSY);
  assign tx_abort      = abort_q;
  assign slice_overrun = ovr_q;

endmodule

// File: tb/tb_slice_tx_arbiter.sv
// Bench for slice_tx_arbiter: directed scenarios plus random traffic, checked every
// cycle against a model built from slice ages and absolute deadline cycles.
module tb_slice_tx_arbiter;
  localparam int DW = 25;
  localparam int GUARD = 16;
  localparam int MARGIN = 1000;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [3:0]    slice_en = '0;
  logic [4*DW-1:0] slice_len = '0;
  logic [3:0]    tx_req = '0;
  logic [4*DW-1:0] tx_dur = '0;
  logic          tx_done = 1'b0;
  logic          overrun_clr = 1'b0;
  logic [3:0]    tx_grant;
  logic          tx_busy, tx_abort, slice_overrun;

  always #5 clk = ~clk;

  slice_tx_arbiter #(.DUR_WIDTH(DW), .GUARD_CYCLES(GUARD), .TIMEOUT_MARGIN(MARGIN)) dut (
    .clk(clk), .rstn(rstn), .slice_en(slice_en), .slice_len(slice_len),
    .tx_req(tx_req), .tx_dur(tx_dur), .tx_done(tx_done), .tx_grant(tx_grant),
    .tx_busy(tx_busy), .tx_abort(tx_abort), .slice_overrun(slice_overrun),
    .overrun_clr(overrun_clr)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: a queue's remaining time follows from how many edges its enable
  // has been seen high; a grant carries an absolute abort cycle.
  int     m_age [4];
  int     m_g = -1;
  int     m_rr = 0;
  bit     m_abort = 0;
  bit     m_ovr = 0;
  longint mcyc = 0;
  longint m_gcyc = 0;
  longint m_abort_at = 0;
  int     new_g;
  bit     found;

  function automatic longint lenq(int i);
    return longint'(slice_len[i*DW +: DW]);
  endfunction
  function automatic longint durq(int i);
    return longint'(tx_dur[i*DW +: DW]);
  endfunction
  function automatic longint m_remain(int i);
    longint r;
    if (m_age[i] == 0) return 0;
    r = lenq(i) - longint'(m_age[i] - 1);
    return (r < 0) ? 0 : r;
  endfunction
  function automatic bit m_elig(int i);
    return slice_en[i] && (m_age[i] >= 1) && tx_req[i] && (m_remain(i) >= durq(i) + GUARD);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) m_age[i] = 0;
      m_g = -1; m_rr = 0; m_abort = 0; m_ovr = 0; mcyc = 0;
    end else begin
      mcyc++;
      new_g = m_g;
      m_abort = 0;
      if ((m_g >= 0) && !slice_en[m_g]) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
      if (m_g < 0) begin
        found = 0;
        for (int o = 0; o < 4; o++) begin
          if (!found && m_elig((m_rr + o) % 4)) begin
            found = 1;
            new_g = (m_rr + o) % 4;
          end
        end
        if (found) begin
          m_gcyc = mcyc;
          m_abort_at = mcyc + durq(new_g) + MARGIN + 1;
          m_rr = (new_g + 1) % 4;
        end
      end else if (tx_done) begin
        new_g = -1;
      end else if (mcyc == m_abort_at) begin
        new_g = -1;
        m_abort = 1;
      end
      for (int i = 0; i < 4; i++) m_age[i] = slice_en[i] ? m_age[i] + 1 : 0;
      m_g = new_g;
    end
  end

  // Observed DUT events and frame responder state.
  int     d_gidx[$];
  longint d_gcyc[$];
  longint d_abort_cyc = -1;
  logic [3:0] d_abort_grant;
  int     d_abort_n = 0;
  logic [3:0] prev_grant = '0;
  bit     rand_mode = 0;
  longint done_dly = 0;
  longint cur_dly = 0;

  task automatic tick();
    @(negedge clk);
    check("grant", tx_grant, (m_g >= 0) ? (64'd1 << m_g) : 64'd0);
    check("busy", tx_busy, (m_g >= 0) ? 1 : 0);
    check("abort", tx_abort, m_abort);
    check("overrun", slice_overrun, m_ovr);
    if ((tx_grant != 0) && (prev_grant == 0)) begin
      for (int i = 0; i < 4; i++) if (tx_grant[i]) d_gidx.push_back(i);
      d_gcyc.push_back(mcyc);
    end
    if (tx_abort) begin
      d_abort_cyc = mcyc;
      d_abort_grant = tx_grant;
      d_abort_n++;
    end
    prev_grant = tx_grant;
    if ((m_g >= 0) && (m_gcyc == mcyc)) begin
      cur_dly = rand_mode ? longint'($urandom_range(1, 80)) : done_dly;
      if (rand_mode) tx_req[m_g] = 1'b0;
    end
    tx_done = (m_g >= 0) && (cur_dly > 0) && (mcyc + 1 == m_gcyc + cur_dly);
    if (rand_mode && (m_g < 0) && ($urandom_range(0, 29) == 0)) tx_done = 1'b1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    slice_en = '0; tx_req = '0; tx_done = 1'b0; overrun_clr = 1'b0;
    slice_len = '0; tx_dur = '0;
    rand_mode = 0; done_dly = 0; cur_dly = 0;
    #12;
    check("rst_grant", tx_grant, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_abort", tx_abort, 0);
    check("rst_overrun", slice_overrun, 0);
    @(negedge clk);
    rstn = 1'b1;
    d_gidx.delete(); d_gcyc.delete();
    d_abort_cyc = -1; d_abort_n = 0; prev_grant = '0;
  endtask

  task automatic wait_grant(input int n, input int budget);
    for (int c = 0; c < budget && d_gidx.size() < n; c++) tick();
  endtask

  longint rise_edge;
  longint g0;

  initial begin
    #1;
    // Fit: 100 >= 80+16, granted one edge after the enable rise is loaded.
    do_reset();
    slice_len[0 +: DW] = 100; tx_dur[0 +: DW] = 80; tx_req = 4'b0001; done_dly = 5;
    tick();
    slice_en = 4'b0001;
    rise_edge = mcyc + 1;
    repeat (4) tick();
    check("fit_grant_cnt", d_gidx.size(), 1);
    if (d_gidx.size() > 0) begin
      check("fit_grant_idx", d_gidx[0], 0);
      check("fit_grant_lat", d_gcyc[0] - rise_edge, 1);
    end

    // No fit: 100 < 90+16 and remain only shrinks.
    do_reset();
    slice_len[0 +: DW] = 100; tx_dur[0 +: DW] = 90; tx_req = 4'b0001;
    tick();
    slice_en = 4'b0001;
    repeat (120) tick();
    check("nofit_grants", d_gidx.size(), 0);

    // Round robin with done 5 cycles after each grant.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      slice_len[i*DW +: DW] = 1000; tx_dur[i*DW +: DW] = 10;
    end
    tx_req = 4'hF; slice_en = 4'hF; done_dly = 5;
    wait_grant(5, 200);
    check("rr_count", d_gidx.size() >= 5, 1);
    for (int j = 0; j < 5 && j < d_gidx.size(); j++) begin
      check("rr_order", d_gidx[j], j % 4);
      if (j > 0) check("rr_gap", d_gcyc[j] - d_gcyc[j-1], 6);
    end

    // Timeout on queue 2, dur 50: abort 1051 edges after grant.
    do_reset();
    slice_len[2*DW +: DW] = 5000; tx_dur[2*DW +: DW] = 50;
    tx_req = 4'b0100; slice_en = 4'b0100; done_dly = 0;
    wait_grant(1, 20);
    for (int c = 0; c < 1200 && d_abort_n == 0; c++) tick();
    check("to_seen", d_abort_n, 1);
    if (d_gidx.size() > 0) begin
      check("to_idx", d_gidx[0], 2);
      check("to_delay", d_abort_cyc - d_gcyc[0], 1051);
    end
    check("to_grant_clr", d_abort_grant, 0);

    // Done in the cycle the timer expires: no abort.
    do_reset();
    slice_len[2*DW +: DW] = 5000; tx_dur[2*DW +: DW] = 50;
    tx_req = 4'b0100; slice_en = 4'b0100; done_dly = 1051;
    wait_grant(1, 20);
    g0 = (d_gcyc.size() > 0) ? d_gcyc[0] : 0;
    for (int c = 0; c < 1200 && mcyc < g0 + 1051; c++) tick();
    check("coll_abort", d_abort_n, 0);
    check("coll_idle", tx_busy, 0);
    tick();
    check("coll_abort_after", d_abort_n, 0);

    // Overrun on queue 1: sticky, set beats clear, grant held until done.
    do_reset();
    slice_len[1*DW +: DW] = 1000; tx_dur[1*DW +: DW] = 20;
    tx_req = 4'b0010; slice_en = 4'b0010; done_dly = 30;
    wait_grant(1, 20);
    repeat (5) tick();
    slice_en = 4'b0000;
    tick();
    tick();
    check("ovr_set", slice_overrun, 1);
    check("ovr_grant_held", tx_grant, 4'b0010);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_set_wins", slice_overrun, 1);
    for (int c = 0; c < 40 && m_g >= 0; c++) tick();
    tick();
    check("ovr_sticky", slice_overrun, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_clr", slice_overrun, 0);

    // Async reset mid-frame, then arbitration restarts at queue 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      slice_len[i*DW +: DW] = 1000; tx_dur[i*DW +: DW] = 10;
    end
    tx_req = 4'hF; slice_en = 4'hF; done_dly = 0;
    wait_grant(1, 20);
    repeat (2) tick();
    check("arst_pre_busy", tx_busy, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_grant", tx_grant, 0);
    check("arst_busy", tx_busy, 0);
    check("arst_abort", tx_abort, 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    d_gidx.delete(); d_gcyc.delete(); prev_grant = '0; cur_dly = 0; done_dly = 4;
    wait_grant(2, 40);
    check("arst_restart_cnt", d_gidx.size(), 2);
    if (d_gidx.size() > 1) begin
      check("arst_restart_q0", d_gidx[0], 0);
      check("arst_restart_q1", d_gidx[1], 1);
    end

    // Random traffic against the model.
    do_reset();
    rand_mode = 1;
    for (int i = 0; i < 4; i++) slice_len[i*DW +: DW] = DW'($urandom_range(20, 200));
    slice_en = 4'($urandom_range(0, 15));
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 39) == 0) slice_en[i] = ~slice_en[i];
        if (!tx_req[i] && ($urandom_range(0, 7) == 0)) begin
          tx_dur[i*DW +: DW] = DW'($urandom_range(1, 150));
          tx_req[i] = 1'b1;
        end
      end
      overrun_clr = ($urandom_range(0, 24) == 0);
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
